div_unit: RTL and testbench

Iterative divider for the M-extension DIV, DIVU, REM and REMU instructions. It sits between the register-file read ports and the register-file write port. It captures rs1/rs2 operand data and the destination index with a start pulse. It computes one quotient bit per cycle using a restoring algorithm, then issues a single-cycle register write. While it works, `busy_o` stalls the issue logic.

---
 rtl/div_unit.sv | 179 +++++++++++++++++
 tb/tb_div_unit.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// div_unit: iterative restoring divider for RISC-V DIV/DIVU/REM/REMU.
// Computes one quotient bit per cycle and issues one register write
// when it finishes. Divide-by-zero and signed overflow finish in one cycle.
module div_unit #(
  parameter int DATA_WIDTH          = 32,
  parameter int NUMBER_OF_REGISTERS = 32
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start_i,
  input  logic [1:0]                             op_i,
  input  logic [DATA_WIDTH-1:0]                  rs1_data_i,
  input  logic [DATA_WIDTH-1:0]                  rs2_data_i,
  input  logic [$clog2(NUMBER_OF_REGISTERS)-1:0] rd_address_i,
  input  logic                                   kill_i,
  output logic                                   busy_o,
  output logic                                   done_o,
  output logic                                   rd_we_o,
  output logic [$clog2(NUMBER_OF_REGISTERS)-1:0] rd_address_o,
  output logic [DATA_WIDTH-1:0]                  rd_data_o
);

  localparam int AW = $clog2(NUMBER_OF_REGISTERS);
  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [DATA_WIDTH-1:0] MIN_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_e;

  state_e                state_q, state_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  we_q, we_d;
  logic [AW-1:0]         rd_q, rd_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  rem_sel_q, rem_sel_d;
  logic [DATA_WIDTH-1:0] quo_q, quo_d;
  logic [DATA_WIDTH-1:0] dvs_q, dvs_d;
  logic [DATA_WIDTH-1:0] rem_q, rem_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  qsign_q, qsign_d;
  logic                  rsign_q, rsign_d;

  logic                  a_neg, b_neg, ovf_in, fast_in;
  logic [DATA_WIDTH-1:0] abs_a, abs_b, fast_res;
  logic [DATA_WIDTH:0]   shifted, diff;
  logic                  fits;
  logic [DATA_WIDTH-1:0] q_fix, r_fix;

  // Operand conditioning and iteration datapath.
  always_comb begin
    a_neg    = ~op_i[0] & rs1_data_i[DATA_WIDTH-1];
    b_neg    = ~op_i[0] & rs2_data_i[DATA_WIDTH-1];
    abs_a    = a_neg ? -rs1_data_i : rs1_data_i;
    abs_b    = b_neg ? -rs2_data_i : rs2_data_i;
    ovf_in   = ~op_i[0] && (rs1_data_i == MIN_NEG) && (rs2_data_i == '1);
    fast_in  = (rs2_data_i == '0) || ovf_in;
    // Divide-by-zero: quotient all ones, remainder is the dividend.
    // Overflow: quotient is the most negative value, remainder zero.
    if (rs2_data_i == '0) fast_res = op_i[1] ? rs1_data_i : '1;
    else                  fast_res = op_i[1] ? '0 : MIN_NEG;
    shifted  = {rem_q, quo_q[DATA_WIDTH-1]};
    diff     = shifted - {1'b0, dvs_q};
    fits     = ~diff[DATA_WIDTH];
    q_fix    = qsign_q ? -quo_q : quo_q;
    r_fix    = rsign_q ? -rem_q : rem_q;
  end

  // Next-state and next-output logic for the IDLE/CALC/DONE sequence.
  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    we_d      = 1'b0;
    rd_d      = rd_q;
    data_d    = data_q;
    rem_sel_d = rem_sel_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    qsign_d   = qsign_q;
    rsign_d   = rsign_q;
    case (state_q)
      S_IDLE: begin
        // busy stays high through the completion cycle, so a start seen
        // while busy_q is set (the done_o cycle) is ignored.
        busy_d = 1'b0;
        if (start_i && !kill_i && !busy_q) begin
          busy_d    = 1'b1;
          rd_d      = rd_address_i;
          rem_sel_d = op_i[1];
          if (fast_in) begin
            // Special cases bypass CALC/DONE so the result lands one cycle later.
            data_d = fast_res;
            done_d = 1'b1;
            we_d   = (rd_address_i != '0);
          end else begin
            state_d = S_CALC;
            quo_d   = abs_a;
            dvs_d   = abs_b;
            rem_d   = '0;
            cnt_d   = CW'(DATA_WIDTH);
            qsign_d = a_neg ^ b_neg;
            rsign_d = a_neg;
          end
        end
      end
      S_CALC: begin
        if (kill_i) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          rem_d = fits ? diff[DATA_WIDTH-1:0] : shifted[DATA_WIDTH-1:0];
          quo_d = {quo_q[DATA_WIDTH-2:0], fits};
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        if (kill_i) begin
          busy_d = 1'b0;
        end else begin
          done_d = 1'b1;
          we_d   = (rd_q != '0);
          data_d = rem_sel_q ? r_fix : q_fix;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      we_q      <= 1'b0;
      rd_q      <= '0;
      data_q    <= '0;
      rem_sel_q <= 1'b0;
      quo_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      qsign_q   <= 1'b0;
      rsign_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      we_q      <= we_d;
      rd_q      <= rd_d;
      data_q    <= data_d;
      rem_sel_q <= rem_sel_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      rem_q     <= rem_d;
      cnt_q     <= cnt_d;
      qsign_q   <= qsign_d;
      rsign_q   <= rsign_d;
    end
  end

  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign rd_we_o      = we_q;
  assign rd_address_o = rd_q;
  assign rd_data_o    = data_q;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed and random checks of div_unit against an
// arithmetic model of the RISC-V M-extension divide/remainder rules.
module tb_div_unit;

  localparam int DW = 32;
  localparam int NR = 32;
  localparam int AW = $clog2(NR);

  logic          clk = 1'b0;
  logic          rst;
  logic          start_i;
  logic [1:0]    op_i;
  logic [DW-1:0] rs1_data_i;
  logic [DW-1:0] rs2_data_i;
  logic [AW-1:0] rd_address_i;
  logic          kill_i;
  logic          busy_o;
  logic          done_o;
  logic          rd_we_o;
  logic [AW-1:0] rd_address_o;
  logic [DW-1:0] rd_data_o;

  int tests  = 0;
  int failed = 0;
  int done_cnt = 0;

  div_unit #(.DATA_WIDTH(DW), .NUMBER_OF_REGISTERS(NR)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i),
    .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
    .rd_address_i(rd_address_i), .kill_i(kill_i),
    .busy_o(busy_o), .done_o(done_o), .rd_we_o(rd_we_o),
    .rd_address_o(rd_address_o), .rd_data_o(rd_data_o)
  );

  always #5 clk = ~clk;

  // Count completion pulses seen at the sampling edge.
  always @(negedge clk) if (done_o === 1'b1) done_cnt++;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: RISC-V M semantics from plain integer arithmetic.
  function automatic logic [DW-1:0] ref_result(input logic [1:0] op, input logic [DW-1:0] a,
                                               input logic [DW-1:0] b);
    int sa, sb;
    sa = a;
    sb = b;
    case (op)
      2'b00: if (b == 0) return '1;
             else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
             else return 32'(sa / sb);
      2'b01: if (b == 0) return '1; else return a / b;
      2'b10: if (b == 0) return a;
             else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
             else return 32'(sa % sb);
      default: if (b == 0) return a; else return a % b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [1:0] op, input logic [DW-1:0] a,
                                     input logic [DW-1:0] b);
    if (b == 0) return 0;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
    return DW + 1;
  endfunction

  // Called right after a negedge; returns at the negedge after the capture edge.
  task automatic start_op(input logic [1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic [AW-1:0] rd);
    start_i = 1'b1; op_i = op; rs1_data_i = a; rs2_data_i = b; rd_address_i = rd;
    @(negedge clk);
    start_i = 1'b0; rs1_data_i = $urandom; rs2_data_i = $urandom; rd_address_i = AW'($urandom);
  endtask

  // Latency counts clock edges after the capture edge until done_o is seen.
  task automatic wait_done(output int lat);
    lat = 0;
    while (done_o !== 1'b1 && lat < 80) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic check_done(input string tag, input int lat, input logic [1:0] op,
                            input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [AW-1:0] rd);
    check({tag, " latency"}, DW'(lat), DW'(ref_latency(op, a, b)));
    check({tag, " data"}, rd_data_o, ref_result(op, a, b));
    check({tag, " we"}, DW'(rd_we_o), DW'(rd != 0));
    check({tag, " addr"}, DW'(rd_address_o), DW'(rd));
    check({tag, " busy"}, DW'(busy_o), 1);
    @(negedge clk);
    check({tag, " done drop"}, DW'(done_o), 0);
    check({tag, " busy drop"}, DW'(busy_o), 0);
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [DW-1:0] a,
                        input logic [DW-1:0] b, input logic [AW-1:0] rd);
    int lat;
    start_op(op, a, b, rd);
    wait_done(lat);
    check_done(tag, lat, op, a, b, rd);
  endtask

  initial begin
    int lat, snap;
    logic [1:0] op;
    logic [DW-1:0] a, b;
    rst = 1'b1; start_i = 1'b0; kill_i = 1'b0; op_i = 2'b00;
    rs1_data_i = '0; rs2_data_i = '0; rd_address_i = '0;
    repeat (3) @(negedge clk);
    check("rst busy", DW'(busy_o), 0);
    check("rst done", DW'(done_o), 0);
    check("rst we", DW'(rd_we_o), 0);
    check("rst addr", DW'(rd_address_o), 0);
    check("rst data", rd_data_o, 0);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases
    run_op("divu 100/7", 2'b01, 100, 7, 5);
    check("divu 100/7 value", rd_data_o, 14);
    run_op("remu 100/7", 2'b11, 100, 7, 5);
    check("remu 100/7 value", rd_data_o, 2);
    run_op("div -7/2", 2'b00, -7, 2, 3);
    check("div -7/2 value", rd_data_o, 32'hFFFF_FFFD);
    run_op("rem -7/2", 2'b10, -7, 2, 3);
    check("rem -7/2 value", rd_data_o, 32'hFFFF_FFFF);
    run_op("div 7/-2", 2'b00, 7, -2, 4);
    run_op("rem 7/-2", 2'b10, 7, -2, 4);
    check("rem 7/-2 value", rd_data_o, 1);
    run_op("divu 5/0", 2'b01, 5, 0, 6);
    run_op("remu 5/0", 2'b11, 5, 0, 6);
    run_op("div -5/0", 2'b00, -5, 0, 7);
    run_op("rem -5/0", 2'b10, -5, 0, 7);
    check("rem -5/0 value", rd_data_o, 32'hFFFF_FFFB);
    run_op("div ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 8);
    run_op("rem ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 8);
    run_op("divu big", 2'b01, 32'hFFFF_FFFF, 1, 9);
    run_op("div min/1", 2'b00, 32'h8000_0000, 1, 9);
    run_op("rd zero", 2'b01, 50, 5, 0);

    // Second start 10 cycles into CALC is ignored
    snap = done_cnt;
    start_op(2'b01, 1000, 3, 10);
    repeat (10) @(negedge clk);
    start_i = 1'b1; op_i = 2'b11; rs1_data_i = 77; rs2_data_i = 5; rd_address_i = 11;
    @(negedge clk);
    start_i = 1'b0;
    wait_done(lat);
    check_done("ignored start", lat + 11, 2'b01, 1000, 3, 10);
    repeat (40) @(negedge clk);
    check("ignored start pulses", DW'(done_cnt - snap), 1);

    // Kill at iteration 20, then restart next cycle
    snap = done_cnt;
    start_op(2'b00, -1234, 17, 12);
    repeat (19) @(negedge clk);
    kill_i = 1'b1;
    @(negedge clk);
    kill_i = 1'b0;
    check("kill busy", DW'(busy_o), 0);
    run_op("after kill", 2'b10, -1234, 17, 13);
    check("kill pulses", DW'(done_cnt - snap), 1);

    // Reset in the middle of CALC
    snap = done_cnt;
    start_op(2'b01, 999, 4, 14);
    repeat (14) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst busy", DW'(busy_o), 0);
    check("midrst done", DW'(done_o), 0);
    check("midrst we", DW'(rd_we_o), 0);
    check("midrst addr", DW'(rd_address_o), 0);
    check("midrst data", rd_data_o, 0);
    repeat (40) @(negedge clk);
    check("midrst no write", DW'(done_cnt - snap), 0);
    run_op("divu 9/3", 2'b01, 9, 3, 15);
    check("divu 9/3 value", rd_data_o, 3);

    // Randomized operations
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom);
      a = $urandom;
      case ($urandom_range(0, 7))
        0: b = 0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = $urandom_range(1, 15);
        3: b = -$urandom_range(1, 15);
        default: b = $urandom;
      endcase
      run_op("random", op, a, b, AW'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
